// File: rtl/coin_acceptor_pkg.sv
// Shared coin codes, channel indices and arbitration helpers for the coin acceptor.
// Coin codes match the ones the downstream soda DFA bench decodes.
package coin_acceptor_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_2    = 2'b10,
    COIN_5    = 2'b11
  } coin_t;

  localparam int NUM_CH = 3;
  localparam int CH_1   = 0;
  localparam int CH_2   = 1;
  localparam int CH_5   = 2;

  // Highest denomination wins when several channels are waiting.
  function automatic logic [NUM_CH-1:0] pick_channel(input logic [NUM_CH-1:0] req);
    logic [NUM_CH-1:0] sel;
    sel = '0;
    if (req[CH_5])      sel[CH_5] = 1'b1;
    else if (req[CH_2]) sel[CH_2] = 1'b1;
    else if (req[CH_1]) sel[CH_1] = 1'b1;
    return sel;
  endfunction

  function automatic coin_t channel_code(input logic [NUM_CH-1:0] sel);
    coin_t code;
    code = COIN_NONE;
    if (sel[CH_5])      code = COIN_5;
    else if (sel[CH_2]) code = COIN_2;
    else if (sel[CH_1]) code = COIN_1;
    return code;
  endfunction

endpackage

// File: rtl/coin_acceptor_fifo.sv
// DEPTH x 2-bit synchronous FIFO holding coin codes between arbiter and emitter.
// A push is still accepted when full provided a pop happens in the same cycle.
module coin_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [1:0]                 din,
  output logic [1:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: sync + debounce per channel, pending flags, priority
// arbiter into a small FIFO, and a paced emitter of single-cycle coin pulses.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            coin1_raw,
  input  logic                            coin2_raw,
  input  logic                            coin5_raw,
  output logic                            in1,
  output logic                            in2,
  output logic                            in5,
  output logic                            reject,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pending
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  logic [1:0]        rst_sync;
  logic              rst_i;
  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] coin_evt;
  logic [NUM_CH-1:0] flag;
  logic [NUM_CH-1:0] push_sel;
  logic [NUM_CH-1:0] flag_clr;
  logic [NUM_CH-1:0] drop;
  logic [1:0]        push_code;
  logic [1:0]        pop_code;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [GW-1:0]     gap_cnt;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  assign raw_vec = {coin5_raw, coin2_raw, coin1_raw};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    logic           s1;
    logic           s2;
    logic           lvl;
    logic           lvl_q;
    logic [DBW-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        lvl    <= 1'b0;
        lvl_q  <= 1'b0;
        db_cnt <= '0;
      end else begin
        s1    <= raw_vec[g];
        s2    <= s1;
        lvl_q <= lvl;
        if (s2 != lvl) begin
          if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
            lvl    <= s2;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DBW'(1);
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end

    // Only insertion (rising debounced level) counts as a coin.
    assign coin_evt[g] = lvl & ~lvl_q;
  end

  always_comb begin
    push_sel  = pick_channel(flag);
    push_code = channel_code(push_sel);
  end

  assign pop      = (gap_cnt == '0) && !fifo_empty;
  assign push     = (|flag) && (!fifo_full || pop);
  assign flag_clr = push ? push_sel : '0;
  assign drop     = coin_evt & flag & ~flag_clr;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      flag   <= '0;
      reject <= 1'b0;
    end else begin
      flag   <= (flag & ~flag_clr) | coin_evt;
      reject <= |drop;
    end
  end

  coin_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (push_code),
    .dout  (pop_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  // Gap counter is a down-counter; a pop is only allowed at terminal count.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      in1     <= 1'b0;
      in2     <= 1'b0;
      in5     <= 1'b0;
      gap_cnt <= '0;
    end else begin
      in1 <= pop && (pop_code == COIN_1);
      in2 <= pop && (pop_code == COIN_2);
      in5 <= pop && (pop_code == COIN_5);
      if (pop)                gap_cnt <= GW'(GAP_CYCLES);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: a default instance and a slow-draining instance share
// the raw sensor lines and are both compared every cycle against a coin-level model.
module tb_coin_acceptor;

  localparam int PW    = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic coin1_raw = 1'b0;
  logic coin2_raw = 1'b0;
  logic coin5_raw = 1'b0;

  logic          a_in1, a_in2, a_in5, a_rej;
  logic [PW-1:0] a_pend;
  logic          b_in1, b_in2, b_in5, b_rej;
  logic [PW-1:0] b_pend;

  coin_acceptor u_dut (
    .clk(clk), .rst_n(rst_n),
    .coin1_raw(coin1_raw), .coin2_raw(coin2_raw), .coin5_raw(coin5_raw),
    .in1(a_in1), .in2(a_in2), .in5(a_in5), .reject(a_rej), .pending(a_pend)
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(2), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(10)) u_dut_slow (
    .clk(clk), .rst_n(rst_n),
    .coin1_raw(coin1_raw), .coin2_raw(coin2_raw), .coin5_raw(coin5_raw),
    .in1(b_in1), .in2(b_in2), .in5(b_in5), .reject(b_rej), .pending(b_pend)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rej_seen = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Coin-level model: denominations (1/2/5) flow through a list, not codes.
  int  m_deb [2] = '{4, 2};
  int  m_gap [2] = '{1, 10};
  int  m_val [3] = '{1, 2, 5};
  int  rel   [2] = '{0, 0};
  bit  s1    [2][3];
  bit  s2    [2][3];
  bit  lvl   [2][3];
  bit  lvl_p [2][3];
  bit  flg   [2][3];
  int  run   [2][3];
  int  lst   [2][DEPTH];
  int  lst_n [2] = '{0, 0};
  int  gap   [2] = '{0, 0};
  int  e_out [2] = '{0, 0};
  int  e_rej [2] = '{0, 0};

  task automatic model_clear(input int i);
    for (int c = 0; c < 3; c++) begin
      s1[i][c] = 0; s2[i][c] = 0; lvl[i][c] = 0; lvl_p[i][c] = 0;
      flg[i][c] = 0; run[i][c] = 0;
    end
    lst_n[i] = 0; gap[i] = 0; e_out[i] = 0; e_rej[i] = 0;
  endtask

  task automatic model_step(input int i, input logic [2:0] raw);
    bit ev [3];
    int pick;
    bit popping, pushing;
    if (!rst_n || rel[i] < 2) begin
      if (!rst_n) rel[i] = 0;
      else        rel[i]++;
      model_clear(i);
      return;
    end
    pick = -1;
    for (int c = 0; c < 3; c++) ev[c] = lvl[i][c] && !lvl_p[i][c];
    for (int c = 2; c >= 0; c--) if (flg[i][c] && pick < 0) pick = c;
    popping = (gap[i] == 0) && (lst_n[i] > 0);
    pushing = (pick >= 0) && (lst_n[i] < DEPTH || popping);
    e_out[i] = popping ? lst[i][0] : 0;
    if (popping) begin
      for (int k = 0; k < DEPTH - 1; k++) lst[i][k] = lst[i][k+1];
      lst_n[i]--;
    end
    if (pushing) begin
      lst[i][lst_n[i]] = m_val[pick];
      lst_n[i]++;
    end
    e_rej[i] = 0;
    for (int c = 0; c < 3; c++) begin
      bit taken;
      taken = pushing && (pick == c);
      if (ev[c] && flg[i][c] && !taken) e_rej[i] = 1;
      flg[i][c] = (flg[i][c] && !taken) || ev[c];
    end
    gap[i] = popping ? m_gap[i] : (gap[i] > 0 ? gap[i] - 1 : 0);
    for (int c = 0; c < 3; c++) begin
      lvl_p[i][c] = lvl[i][c];
      if (s2[i][c] != lvl[i][c]) begin
        run[i][c]++;
        if (run[i][c] == m_deb[i]) begin
          lvl[i][c] = s2[i][c];
          run[i][c] = 0;
        end
      end else begin
        run[i][c] = 0;
      end
      s2[i][c] = s1[i][c];
      s1[i][c] = raw[c];
    end
  endtask

  always @(posedge clk) begin
    model_step(0, {coin5_raw, coin2_raw, coin1_raw});
    model_step(1, {coin5_raw, coin2_raw, coin1_raw});
  end

  function automatic int coin_sum(input logic i1, input logic i2, input logic i5);
    return (i1 ? 1 : 0) + (i2 ? 2 : 0) + (i5 ? 5 : 0);
  endfunction

  always @(negedge clk) begin
    check_val("dflt_coin", coin_sum(a_in1, a_in2, a_in5), e_out[0]);
    check_val("dflt_reject", int'(a_rej), e_rej[0]);
    check_val("dflt_pending", int'(a_pend), lst_n[0]);
    check_val("slow_coin", coin_sum(b_in1, b_in2, b_in5), e_out[1]);
    check_val("slow_reject", int'(b_rej), e_rej[1]);
    check_val("slow_pending", int'(b_pend), lst_n[1]);
    if (b_rej) rej_seen++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_dflt"}, int'({a_in1, a_in2, a_in5, a_rej, a_pend}), 0);
    check_val({tag, "_slow"}, int'({b_in1, b_in2, b_in5, b_rej, b_pend}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n_in1, n_in5, n_in2, peak, pulses, v;
    int seq[$];
    int idx[$];
    int dur [3];
    logic [2:0] lv;

    #1 rst_n = 1'b0;
    step(2);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    step(4);
    check_all_zero("post_release");

    // Clean held 2-coin: one in2 pulse, DEBOUNCE_CYCLES+4 edges after first sample.
    coin2_raw = 1'b1;
    lat = -1; n_in1 = 0; n_in2 = 0; n_in5 = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (a_in2 && lat < 0) lat = k;
      n_in1 += a_in1; n_in2 += a_in2; n_in5 += a_in5;
      if (k == 19) coin2_raw = 1'b0;
    end
    check_val("t1_latency", lat, 8);
    check_val("t1_in2_count", n_in2, 1);
    check_val("t1_other_count", n_in1 + n_in5, 0);
    step(60);

    // Bouncy 1-coin: toggles every 2 cycles, then held.
    n_in1 = 0;
    for (int k = 0; k < 10; k++) begin
      coin1_raw = k[1];
      @(posedge clk); #1;
      n_in1 += a_in1;
    end
    check_val("t2_bounce_pulses", n_in1, 0);
    coin1_raw = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      n_in1 += a_in1;
    end
    check_val("t2_held_pulses", n_in1, 1);
    coin1_raw = 1'b0;
    step(60);

    // Simultaneous coins: order 5, 2, 1, one idle cycle apart, pending peaks at 2.
    coin1_raw = 1'b1; coin2_raw = 1'b1; coin5_raw = 1'b1;
    peak = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      v = coin_sum(a_in1, a_in2, a_in5);
      if (v != 0) begin seq.push_back(v); idx.push_back(k); end
      if (int'(a_pend) > peak) peak = int'(a_pend);
      if (k == 19) begin coin1_raw = 1'b0; coin2_raw = 1'b0; coin5_raw = 1'b0; end
    end
    check_val("t3_pulse_count", seq.size(), 3);
    if (seq.size() == 3) begin
      check_val("t3_first", seq[0], 5);
      check_val("t3_second", seq[1], 2);
      check_val("t3_third", seq[2], 1);
      check_val("t3_spacing_a", idx[1] - idx[0], 2);
      check_val("t3_spacing_b", idx[2] - idx[1], 2);
    end
    check_val("t3_peak_pending", peak, 2);
    step(80);

    // Reset while coins are buffered in the slow instance.
    coin1_raw = 1'b1; coin2_raw = 1'b1; coin5_raw = 1'b1;
    step(6);
    coin1_raw = 1'b0; coin2_raw = 1'b0; coin5_raw = 1'b0;
    v = 0;
    for (int k = 0; k < 30 && v == 0; k++) begin
      @(posedge clk); #1;
      if (b_pend >= 2) v = 1;
    end
    check_val("t6_pending_built", v, 1);
    step(1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async_reset");
    step(1);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      pulses += coin_sum(a_in1, a_in2, a_in5) + coin_sum(b_in1, b_in2, b_in5);
    end
    check_val("t6_no_pulses_after_reset", pulses, 0);
    step(1);

    // Random sensor activity with bounce, bursts and occasional resets.
    for (int c = 0; c < 3; c++) dur[c] = $urandom_range(1, 14);
    lv = 3'b000;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < 3; c++) begin
        if (dur[c] == 0) begin
          lv[c] = ~lv[c];
          dur[c] = $urandom_range(1, 14);
        end else begin
          dur[c]--;
        end
      end
      coin1_raw = lv[0]; coin2_raw = lv[1]; coin5_raw = lv[2];
      if (t % 997 == 500) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("rand_async_reset");
        step(1);
        rst_n = 1'b1;
      end else begin
        step(1);
      end
    end
    coin1_raw = 1'b0; coin2_raw = 1'b0; coin5_raw = 1'b0;
    step(80);
    check_val("slow_reject_exercised", int'(rej_seen > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
